gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Parametrised iterative GCD unit that replaces the fixed 8-bit subtract/swap GCD circuit.
- Adds configurable operand width and a selectable algorithm (subtract/swap or binary Stein).
- Adds explicit zero-operand handling, a one-cycle done pulse and a saturating iteration counter.
- Sits as a shared arithmetic coprocessor behind a start/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- MODE, 0, algorithm select: 0 = subtract/swap, 1 = binary Stein.
- ITW, 16, width of the iteration counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset.
- start  in  1  request; accepted only when ready=1.
- ina  in  WIDTH  operand A, sampled on the accepted start edge only.
- inb  in  WIDTH  operand B, sampled on the accepted start edge only.
- ready  out  1  1 = idle, can accept start.
- done  out  1  one-cycle pulse: out/iters valid and freshly updated.
- out  out  WIDTH  last result; holds until the next result.
- iters  out  ITW  non-terminal RUN steps of the last computation; saturates at all-ones.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset (any state, including mid-computation):
  - State returns to IDLE.
  - ready=1, done=0, out=0, iters=0.
  - Internal a, b, k registers cleared.
  - The operation in flight is discarded; no done pulse.
- States: IDLE, RUN. ready = (state==IDLE). All outputs are registered.
- IDLE:
  - On start=1: load a=ina, b=inb, k=0, step counter=0; go to RUN.
  - start while in RUN is ignored; operands are not resampled.
- RUN, MODE 0: one action per cycle, first match wins.
  - b==0 or a==b: terminal; result=a.
  - a<b: swap a and b.
  - else: a=a-b.
- RUN, MODE 1: one action per cycle, first match wins.
  - a==0: terminal; result=b<<k.
  - b==0 or a==b: terminal; result=a<<k.
  - both even: a>>=1, b>>=1, k++.
  - a even: a>>=1.
  - b even: b>>=1.
  - both odd, a>b: a=(a-b)>>1.
  - both odd, a<=b: b=(b-a)>>1.
  - k is wide enough to hold log2(WIDTH)+1; result never exceeds max(ina,inb), so no overflow.
- Non-terminal RUN cycle: step counter +1, saturating at 2^ITW-1.
- Terminal RUN edge:
  - out<=result, iters<=step counter, done<=1.
  - State goes to IDLE, so ready=1 in the same cycle done=1.
- done is 0 in every other cycle.
- Latency: with start accepted at edge t0 and N non-terminal steps, done=1 in the cycle after edge t0+N+1. Minimum is 2 cycles after start (ina==inb or a zero operand).
- start=1 in the done cycle is accepted (back-to-back operation); out/iters hold until the next terminal edge.
- Zero cases:
  - gcd(0,0)=0.
  - gcd(x,0)=gcd(0,x)=x.
  - MODE 0, ina=0, inb=x: one swap, then terminal; iters=1.
  - MODE 1: a zero operand is immediately terminal; iters=0.
- All arithmetic is unsigned WIDTH-bit. Subtraction is only performed when minuend >= subtrahend, so it never wraps.

Test Plan:
- MODE0, WIDTH8, start with ina=12, inb=18 -> swap, sub, swap, sub, terminal. done=1 in 6th cycle after start edge; out=6; iters=4; ready=0 in between.
- MODE0: (0,0) -> out=0, iters=0, done 2 cycles after start. (0,9) -> out=9, iters=1.
- MODE1, WIDTH8, (48,18) -> 5 steps (halve both k=1, a 12, 6, 3, b=(9-3)>>1=3), then terminal. out=6, iters=5.
- MODE1, WIDTH16, (65535,255) -> out=255. (40000,0) -> out=40000, iters=0.
- Handshake: pulse start with (100,75) during RUN of a (12,18) job -> ignored; first done gives out=6. start asserted in the done cycle with (100,75) -> accepted, next done gives out=25. done is never high 2 consecutive cycles.
- Reset: assert rst for 1 cycle mid-RUN of (200,3) -> next cycle ready=1, done=0, out=0, iters=0. A new (200,3) job completes with out=1. ITW=4 with (255,1) in MODE0 -> iters saturates at 15.

Source files
------------

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - iterative GCD coprocessor (subtract/swap or binary Stein) with start/ready handshake
module gcd_engine #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int ITW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [ITW-1:0]   iters
);
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a, b;
    logic [KW-1:0]    k;
    logic [ITW-1:0]   cnt;

    logic             term;
    logic [WIDTH-1:0] res, na, nb;
    logic [KW-1:0]    nk;

    // One RUN step: either a terminal result or the next (a, b, k).
    always_comb begin
        term = 1'b0;
        res  = a;
        na   = a;
        nb   = b;
        nk   = k;
        if (MODE == 0) begin
            if (b == '0 || a == b) begin
                term = 1'b1;
                res  = a;
            end else if (a < b) begin
                na = b;
                nb = a;
            end else begin
                na = a - b;
            end
        end else begin
            if (a == '0) begin
                term = 1'b1;
                res  = b << k;
            end else if (b == '0 || a == b) begin
                term = 1'b1;
                res  = a << k;
            end else if (!a[0] && !b[0]) begin
                na = a >> 1;
                nb = b >> 1;
                nk = k + 1'b1;
            end else if (!a[0]) begin
                na = a >> 1;
            end else if (!b[0]) begin
                nb = b >> 1;
            end else if (a > b) begin
                na = (a - b) >> 1;
            end else begin
                nb = (b - a) >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            out   <= '0;
            iters <= '0;
            a     <= '0;
            b     <= '0;
            k     <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= ina;
                        b     <= inb;
                        k     <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (term) begin
                        out   <= res;
                        iters <= cnt;
                        done  <= 1'b1;
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        a <= na;
                        b <= nb;
                        k <= nk;
                        if (cnt != '1)
                            cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - self-checking bench for gcd_engine across four parameter sets
module tb_gcd_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start;
    logic [15:0] ina [4];
    logic [15:0] inb [4];
    logic [3:0]  ready, done;
    logic [7:0]  out0, out1, out3;
    logic [15:0] out2;
    logic [15:0] it0, it1, it2;
    logic [3:0]  it3;
    logic [15:0] outv [4];
    logic [15:0] itv  [4];

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    localparam int MODE_OF [4] = '{0, 1, 1, 0};
    localparam int SAT_OF  [4] = '{65535, 65535, 65535, 15};
    localparam int MASK_OF [4] = '{255, 255, 65535, 255};

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(8),  .MODE(0), .ITW(16)) u0 (.clk(clk), .rst(rst), .start(start[0]),
        .ina(ina[0][7:0]), .inb(inb[0][7:0]), .ready(ready[0]), .done(done[0]), .out(out0), .iters(it0));
    gcd_engine #(.WIDTH(8),  .MODE(1), .ITW(16)) u1 (.clk(clk), .rst(rst), .start(start[1]),
        .ina(ina[1][7:0]), .inb(inb[1][7:0]), .ready(ready[1]), .done(done[1]), .out(out1), .iters(it1));
    gcd_engine #(.WIDTH(16), .MODE(1), .ITW(16)) u2 (.clk(clk), .rst(rst), .start(start[2]),
        .ina(ina[2]), .inb(inb[2]), .ready(ready[2]), .done(done[2]), .out(out2), .iters(it2));
    gcd_engine #(.WIDTH(8),  .MODE(0), .ITW(4))  u3 (.clk(clk), .rst(rst), .start(start[3]),
        .ina(ina[3][7:0]), .inb(inb[3][7:0]), .ready(ready[3]), .done(done[3]), .out(out3), .iters(it3));

    always_comb begin
        outv[0] = {8'h00, out0};
        outv[1] = {8'h00, out1};
        outv[2] = out2;
        outv[3] = {8'h00, out3};
        itv[0]  = it0;
        itv[1]  = it1;
        itv[2]  = it2;
        itv[3]  = {12'h000, it3};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: walk the algorithm's step rules on plain integers.
    function automatic void gcd_ref(input int mode, input int x, input int y,
                                    output int res, output int steps);
        int a = x, b = y, k = 0, t;
        steps = 0;
        forever begin
            if (mode == 0) begin
                if (b == 0 || a == b) begin res = a; return; end
                if (a < b) begin t = a; a = b; b = t; end
                else a = a - b;
            end else begin
                if (a == 0) begin res = b << k; return; end
                if (b == 0 || a == b) begin res = a << k; return; end
                if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; k++; end
                else if (a % 2 == 0) a = a / 2;
                else if (b % 2 == 0) b = b / 2;
                else if (a > b) a = (a - b) / 2;
                else b = (b - a) / 2;
            end
            steps++;
        end
    endfunction

    logic        m_ready [4];
    logic        m_done  [4];
    int          m_out   [4];
    int          m_it    [4];
    bit          m_busy  [4];
    int          m_cnt   [4];
    int          m_pout  [4];
    int          m_pit   [4];

    // Transaction-level model: result known at accept, appears N+1 edges later.
    always @(posedge clk) begin
        int r, s;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_ready[i] <= 1'b1; m_done[i] <= 1'b0; m_out[i] <= 0; m_it[i] <= 0;
                m_busy[i] <= 1'b0; m_cnt[i] <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (m_cnt[i] == 1) begin
                        m_busy[i] <= 1'b0; m_ready[i] <= 1'b1; m_done[i] <= 1'b1;
                        m_out[i] <= m_pout[i]; m_it[i] <= m_pit[i];
                    end else begin
                        m_cnt[i] <= m_cnt[i] - 1;
                    end
                end else if (start[i] === 1'b1) begin
                    gcd_ref(MODE_OF[i], int'(ina[i]) & MASK_OF[i], int'(inb[i]) & MASK_OF[i], r, s);
                    m_pout[i] <= r;
                    m_pit[i]  <= (s > SAT_OF[i]) ? SAT_OF[i] : s;
                    m_cnt[i]  <= s + 1;
                    m_busy[i] <= 1'b1;
                    m_ready[i] <= 1'b0;
                end
            end
        end
    end

    logic [3:0] prev_done = 4'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("ready[%0d]", i), {31'b0, ready[i]}, {31'b0, m_ready[i]});
                check($sformatf("done[%0d]", i),  {31'b0, done[i]},  {31'b0, m_done[i]});
                check($sformatf("out[%0d]", i),   {16'b0, outv[i]},  m_out[i]);
                check($sformatf("iters[%0d]", i), {16'b0, itv[i]},   m_it[i]);
                check($sformatf("done_twice[%0d]", i), {31'b0, done[i] & prev_done[i]}, 0);
            end
        end
        prev_done <= done;
    end

    task automatic wait_done(input int i, output int lat);
        lat = 1;
        while (done[i] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("done_seen[%0d]", i), {31'b0, done[i]}, 1);
    endtask

    task automatic job(input int i, input int a, input int b,
                       input int e_out, input int e_it, input int e_lat);
        int lat;
        @(negedge clk);
        start[i] = 1'b1; ina[i] = 16'(a); inb[i] = 16'(b);
        @(negedge clk);
        start[i] = 1'b0;
        wait_done(i, lat);
        check($sformatf("lit_out[%0d](%0d,%0d)", i, a, b), {16'b0, outv[i]}, e_out);
        check($sformatf("lit_iters[%0d](%0d,%0d)", i, a, b), {16'b0, itv[i]}, e_it);
        check($sformatf("lit_latency[%0d](%0d,%0d)", i, a, b), lat, e_lat);
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 4'b0;
        for (int i = 0; i < 4; i++) begin ina[i] = 16'h0; inb[i] = 16'h0; end
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("lit_reset_ready", {31'b0, ready[0]}, 1);
        check("lit_reset_out", {16'b0, outv[0]}, 0);

        job(0, 12, 18, 6, 4, 6);
        job(0, 0, 0, 0, 0, 2);
        job(0, 0, 9, 9, 1, 3);
        job(0, 9, 0, 9, 0, 2);
        job(1, 48, 18, 6, 5, 7);
        job(1, 0, 7, 7, 0, 2);
        job(2, 65535, 255, 255, 8, 10);
        job(2, 40000, 0, 40000, 0, 2);
        job(3, 255, 1, 1, 15, 256);

        // Start pulsed mid-run is ignored; start in the done cycle is taken.
        @(negedge clk);
        start[0] = 1'b1; ina[0] = 16'd12; inb[0] = 16'd18;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        check("lit_busy_ready", {31'b0, ready[0]}, 0);
        start[0] = 1'b1; ina[0] = 16'd100; inb[0] = 16'd75;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, lat);
        check("lit_ignored_start_out", {16'b0, outv[0]}, 6);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("lit_out_holds", {16'b0, outv[0]}, 6);
        wait_done(0, lat);
        check("lit_b2b_out", {16'b0, outv[0]}, 25);

        // Reset mid-run discards the job.
        @(negedge clk);
        start[0] = 1'b1; ina[0] = 16'd200; inb[0] = 16'd3;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("lit_rst_ready", {31'b0, ready[0]}, 1);
        check("lit_rst_done", {31'b0, done[0]}, 0);
        check("lit_rst_out", {16'b0, outv[0]}, 0);
        check("lit_rst_iters", {16'b0, itv[0]}, 0);
        job(0, 200, 3, 1, 70, 72);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
